axi_dma_lite_regs: RTL and testbench
====================================

Name: axi_dma_lite_regs

Overview:
AXI4-Lite slave (responder) implementing the MM2S/S2MM control/status register subset of a simple DMA engine. It is the target end of the DMA configuration write sequence: DMACR, then SA/DA, then LENGTH. It decodes register accesses, holds per-channel address and length, and issues a start pulse to the local datamover. It tracks busy/idle, and raises a write-1-to-clear completion interrupt. It sits between the AXI-Lite interconnect and the datamover core.

Parameters:
S_AXI_ADDR_WIDTH, 32, AXI-Lite address width; only addr[7:2] are decoded.
S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
LEN_WIDTH, 26, implemented bits of each LENGTH register.

Ports:
S_AXI_ACLK  in  1  the single clock.
S_AXI_ARESETN  in  1  asynchronous, active-low reset.
S_AXI_AWADDR  in  S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake.
S_AXI_ARADDR  in  S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake.
MM2S_START, S2MM_START  out  1  one-cycle transfer start pulse.
MM2S_ADDR, S2MM_ADDR  out  32  SA / DA register value.
MM2S_LEN, S2MM_LEN  out  LEN_WIDTH  LENGTH register value.
MM2S_DONE, S2MM_DONE  in  1  one-cycle completion pulse from the datamover.
MM2S_IRQ, S2MM_IRQ  out  1  level interrupt.

Behaviour:
- Reset (ARESETN low, asynchronous): all registers, READYs, VALIDs, RESP, RDATA, START and IRQ go to 0; both channels idle.
- Register map (offset = addr[7:0], low 2 bits ignored):
  - 0x00/0x30 DMACR: RW bit0 RS, RW bit12 IOC_IrqEn; other bits read 0.
  - 0x04/0x34 DMASR: RO bit0 Halted = ~RS & idle; RO bit1 Idle; bit12 IOC_Irq is write-1-to-clear.
  - 0x18/0x48 SA/DA: RW 32 bits.
  - 0x28/0x58 LENGTH: RW, LEN_WIDTH bits.
- WSTRB gates each byte lane on RW registers and on W1C.
- Write path:
  - AWREADY is high while the AW holding register is empty; WREADY is high while the W holding register is empty. AW and W are accepted independently, in either order.
  - The register update occurs in the cycle both holding registers are full and BVALID is low, or BVALID is high and BREADY is high. Both holding registers free in that cycle.
  - BVALID rises the next cycle and holds until BREADY.
  - Back-to-back throughput: one write per 2 cycles.
- Read path:
  - ARREADY = ~RVALID.
  - On accept, RDATA and RRESP are registered and RVALID rises the next cycle. RVALID holds, with RDATA stable, until RREADY.
- Response: BRESP/RRESP = OKAY; unmapped offsets read 0 and ignore writes (see the optional feature).
- Channel FSM per channel: IDLE -> BUSY -> IDLE.
  - IDLE->BUSY: LENGTH write with RS=1, WSTRB!=0 and written length!=0. The START pulse is asserted the cycle after the write commits, and Idle clears in that same cycle.
  - A LENGTH write with value 0 or RS=0 updates the register but does not start a transfer.
  - A LENGTH, SA or DA write while BUSY is ignored (register unchanged), response still OKAY.
  - BUSY->IDLE on DONE: Idle=1 and IOC_Irq=1 the next cycle. A DONE pulse received while IDLE is ignored.
  - Clearing RS while BUSY does not abort; Halted asserts after DONE.
- IRQ = IOC_Irq & IOC_IrqEn, registered.
- Simultaneous DONE and W1C of IOC_Irq in the same cycle: set wins.
- Simultaneous read and write of the same register: the read returns the pre-write value.
- Reset mid-transfer: channel returns to IDLE; the datamover is reset by the same reset.

Optional Feature:
DMA_LITE_SLVERR_EN
- Defined: accesses to unmapped offsets, and writes to any DMASR bit other than bit12, return SLVERR (2'b10); no state change occurs, and unmapped reads return data 0.
- Undefined: all responses are OKAY.

Test Plan:
- Reset, then read every mapped offset: expect 0, except DMASR = 0x00000003 (Halted, Idle).
- Write 0x30=0x1001, 0x48=0x1000_0000, 0x58=0x400: expect S2MM_START high for exactly 1 cycle with S2MM_ADDR=0x1000_0000, S2MM_LEN=0x400; then read 0x34 = 0x00000000.
- Pulse S2MM_DONE: expect S2MM_IRQ=1 and 0x34 reads 0x00001002. Write 0x34=0x1000: expect IRQ=0 and 0x34 reads 0x00000002.
- Present W 3 cycles before AW, with BREADY held low 4 cycles: expect AWREADY/WREADY low while the respective holding register is full, BVALID held, and a single register update.
- Pulse MM2S_DONE in the same cycle as a W1C write to 0x04: expect IOC_Irq=1 afterward. A LENGTH write of 0 with RS=1 produces no START.
- With DMA_LITE_SLVERR_EN defined, read 0x10: expect RRESP=2'b10 and RDATA=0; without the macro, expect RRESP=2'b00.

Source files
------------

// File: rtl/axi_dma_lite_regs.sv
// AXI4-Lite control/status register block for a two-channel (MM2S/S2MM) DMA datamover.
// Optional feature macro: DMA_LITE_SLVERR_EN (SLVERR on unmapped offsets and illegal DMASR writes).
module axi_dma_lite_regs #(
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int LEN_WIDTH        = 26
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          MM2S_START,
    output logic                          S2MM_START,
    output logic [31:0]                   MM2S_ADDR,
    output logic [31:0]                   S2MM_ADDR,
    output logic [LEN_WIDTH-1:0]          MM2S_LEN,
    output logic [LEN_WIDTH-1:0]          S2MM_LEN,
    input  logic                          MM2S_DONE,
    input  logic                          S2MM_DONE,
    output logic                          MM2S_IRQ,
    output logic                          S2MM_IRQ
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} ch_state_t;

    localparam logic [5:0] A_MM2S_CR  = 6'h00;
    localparam logic [5:0] A_MM2S_SR  = 6'h01;
    localparam logic [5:0] A_MM2S_SA  = 6'h06;
    localparam logic [5:0] A_MM2S_LEN = 6'h0A;
    localparam logic [5:0] A_S2MM_CR  = 6'h0C;
    localparam logic [5:0] A_S2MM_SR  = 6'h0D;
    localparam logic [5:0] A_S2MM_DA  = 6'h12;
    localparam logic [5:0] A_S2MM_LEN = 6'h16;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] f_lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] strb);
        return (old_v & ~f_lane_mask(strb)) | (new_v & f_lane_mask(strb));
    endfunction

    logic                 r_aw_full, r_w_full, r_awready, r_wready, r_bvalid;
    logic [5:0]           r_aw_idx;
    logic [31:0]          r_w_data;
    logic [3:0]           r_w_strb;
    logic [1:0]           r_bresp;
    logic                 r_arready, r_rvalid;
    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;

    ch_state_t            r_state [2];
    logic [1:0]           r_rs, r_ioc_en, r_ioc, r_irq, r_start;
    logic [31:0]          r_addr [2];
    logic [LEN_WIDTH-1:0] r_len [2];

    logic                 w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_wr_err, w_rd_err;
    logic                 w_aw_full_nxt, w_w_full_nxt, w_rvalid_nxt;
    logic                 w_wr_map, w_wr_ch, w_wr_cr, w_wr_sr, w_wr_sa, w_wr_len, w_sr_bad;
    logic [1:0]           w_wr_chsel, w_done, w_idle, w_go;
    logic [1:0]           w_cr_we, w_sr_we, w_sa_we, w_len_we;
    logic [31:0]          w_wmask;
    logic [LEN_WIDTH-1:0] w_len_mask;
    logic [LEN_WIDTH-1:0] w_len_new [2];
    ch_state_t            w_st_nxt [2];
    logic                 w_rd_map;
    logic [31:0]          w_rd_data;
    logic                 w_unused_bits;

    assign w_aw_hs  = S_AXI_AWVALID & r_awready;
    assign w_w_hs   = S_AXI_WVALID & r_wready;
    assign w_ar_hs  = S_AXI_ARVALID & r_arready;
    // A new update may retire only when no response is pending or the pending one drains now.
    assign w_commit = r_aw_full & r_w_full & (~r_bvalid | S_AXI_BREADY);
    assign w_wr_ok  = w_commit & ~w_wr_err;
    assign w_done   = {S2MM_DONE, MM2S_DONE};
    assign w_wmask  = f_lane_mask(r_w_strb);
    assign w_len_mask = w_wmask[LEN_WIDTH-1:0];
    assign w_sr_bad = |(r_w_data & w_wmask & ~32'h0000_1000);

    assign w_aw_full_nxt = w_commit ? 1'b0 : (w_aw_hs ? 1'b1 : r_aw_full);
    assign w_w_full_nxt  = w_commit ? 1'b0 : (w_w_hs ? 1'b1 : r_w_full);
    assign w_rvalid_nxt  = w_ar_hs ? 1'b1 : ((r_rvalid & S_AXI_RREADY) ? 1'b0 : r_rvalid);

    assign w_unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[S_AXI_ADDR_WIDTH-1:8], S_AXI_AWADDR[1:0],
                             S_AXI_ARADDR[S_AXI_ADDR_WIDTH-1:8], S_AXI_ARADDR[1:0]};

`ifdef DMA_LITE_SLVERR_EN
    assign w_wr_err = ~w_wr_map | (w_wr_sr & w_sr_bad);
    assign w_rd_err = ~w_rd_map;
`else
    logic w_unused_cfg;
    assign w_wr_err     = 1'b0;
    assign w_rd_err     = 1'b0;
    assign w_unused_cfg = w_wr_map ^ w_sr_bad ^ w_rd_map;
`endif

    // Decode the held write address into register kind and channel.
    always_comb begin
        w_wr_map = 1'b1;
        w_wr_ch  = 1'b0;
        w_wr_cr  = 1'b0;
        w_wr_sr  = 1'b0;
        w_wr_sa  = 1'b0;
        w_wr_len = 1'b0;
        case (r_aw_idx)
            A_MM2S_CR:  w_wr_cr = 1'b1;
            A_MM2S_SR:  w_wr_sr = 1'b1;
            A_MM2S_SA:  w_wr_sa = 1'b1;
            A_MM2S_LEN: w_wr_len = 1'b1;
            A_S2MM_CR:  begin w_wr_ch = 1'b1; w_wr_cr  = 1'b1; end
            A_S2MM_SR:  begin w_wr_ch = 1'b1; w_wr_sr  = 1'b1; end
            A_S2MM_DA:  begin w_wr_ch = 1'b1; w_wr_sa  = 1'b1; end
            A_S2MM_LEN: begin w_wr_ch = 1'b1; w_wr_len = 1'b1; end
            default:    w_wr_map = 1'b0;
        endcase
        if (w_wr_ch) begin
            w_wr_chsel = 2'b10;
        end else begin
            w_wr_chsel = 2'b01;
        end
    end

    // Per-channel write enables, start qualification and IDLE/BUSY next state.
    always_comb begin
        w_idle   = 2'b00;
        w_go     = 2'b00;
        w_cr_we  = 2'b00;
        w_sr_we  = 2'b00;
        w_sa_we  = 2'b00;
        w_len_we = 2'b00;
        for (int c = 0; c < 2; c++) begin
            w_idle[c]    = (r_state[c] == ST_IDLE);
            w_cr_we[c]   = w_wr_ok & w_wr_cr  & w_wr_chsel[c];
            w_sr_we[c]   = w_wr_ok & w_wr_sr  & w_wr_chsel[c];
            w_sa_we[c]   = w_wr_ok & w_wr_sa  & w_wr_chsel[c];
            w_len_we[c]  = w_wr_ok & w_wr_len & w_wr_chsel[c];
            w_len_new[c] = (r_len[c] & ~w_len_mask) | (r_w_data[LEN_WIDTH-1:0] & w_len_mask);
            w_go[c]      = w_len_we[c] & w_idle[c] & r_rs[c] & (|r_w_strb) & (|w_len_new[c]);
            case (r_state[c])
                ST_IDLE: w_st_nxt[c] = w_go[c] ? ST_BUSY : ST_IDLE;
                ST_BUSY: w_st_nxt[c] = w_done[c] ? ST_IDLE : ST_BUSY;
                default: w_st_nxt[c] = ST_IDLE;
            endcase
        end
    end

    // Read mux on the live AR address; registers sampled before any same-cycle write lands.
    always_comb begin
        w_rd_map  = 1'b1;
        w_rd_data = 32'h0000_0000;
        case (S_AXI_ARADDR[7:2])
            A_MM2S_CR:  w_rd_data = {19'd0, r_ioc_en[0], 11'd0, r_rs[0]};
            A_MM2S_SR:  w_rd_data = {19'd0, r_ioc[0], 10'd0, w_idle[0], ~r_rs[0] & w_idle[0]};
            A_MM2S_SA:  w_rd_data = r_addr[0];
            A_MM2S_LEN: w_rd_data = {{(32-LEN_WIDTH){1'b0}}, r_len[0]};
            A_S2MM_CR:  w_rd_data = {19'd0, r_ioc_en[1], 11'd0, r_rs[1]};
            A_S2MM_SR:  w_rd_data = {19'd0, r_ioc[1], 10'd0, w_idle[1], ~r_rs[1] & w_idle[1]};
            A_S2MM_DA:  w_rd_data = r_addr[1];
            A_S2MM_LEN: w_rd_data = {{(32-LEN_WIDTH){1'b0}}, r_len[1]};
            default:    begin w_rd_map = 1'b0; w_rd_data = 32'h0000_0000; end
        endcase
    end

    // Write channel holding registers, registered READYs and the B response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_idx  <= 6'd0;
            r_w_data  <= 32'h0000_0000;
            r_w_strb  <= 4'h0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_awready <= ~w_aw_full_nxt;
            r_wready  <= ~w_w_full_nxt;
            if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[7:2];
            if (w_w_hs) begin
                r_w_data <= S_AXI_WDATA[31:0];
                r_w_strb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: data and response captured on AR accept, held until R handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'h0000_0000;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= ~w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Channel state, control/config registers, completion flag and interrupt.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rs     <= 2'b00;
            r_ioc_en <= 2'b00;
            r_ioc    <= 2'b00;
            r_irq    <= 2'b00;
            r_start  <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                r_state[c] <= ST_IDLE;
                r_addr[c]  <= 32'h0000_0000;
                r_len[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                r_state[c] <= w_st_nxt[c];
                r_start[c] <= w_go[c];
                if (w_cr_we[c] & r_w_strb[0]) r_rs[c] <= r_w_data[0];
                if (w_cr_we[c] & r_w_strb[1]) r_ioc_en[c] <= r_w_data[12];
                if (w_sa_we[c] & w_idle[c]) r_addr[c] <= f_merge(r_addr[c], r_w_data, r_w_strb);
                if (w_len_we[c] & w_idle[c]) r_len[c] <= w_len_new[c];
                // A completion landing with a W1C in the same cycle keeps the flag set.
                if (~w_idle[c] & w_done[c]) begin
                    r_ioc[c] <= 1'b1;
                end else if (w_sr_we[c] & r_w_strb[1] & r_w_data[12]) begin
                    r_ioc[c] <= 1'b0;
                end
                r_irq[c] <= r_ioc[c] & r_ioc_en[c];
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign MM2S_START    = r_start[0];
    assign S2MM_START    = r_start[1];
    assign MM2S_ADDR     = r_addr[0];
    assign S2MM_ADDR     = r_addr[1];
    assign MM2S_LEN      = r_len[0];
    assign S2MM_LEN      = r_len[1];
    assign MM2S_IRQ      = r_irq[0];
    assign S2MM_IRQ      = r_irq[1];

endmodule

// File: tb/tb_axi_dma_lite_regs.sv
// Directed bench for axi_dma_lite_regs: read/start expectations queued as scoreboards.
module tb_axi_dma_lite_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        mm2s_start, s2mm_start, mm2s_done, s2mm_done, mm2s_irq, s2mm_irq;
    logic [31:0] mm2s_addr, s2mm_addr;
    logic [25:0] mm2s_len, s2mm_len;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [33:0] rd_q[$];
    logic [57:0] mm2s_q[$];
    logic [57:0] s2mm_q[$];
    logic [57:0] mm2s_e, s2mm_e;

    always #5 clk = ~clk;

    axi_dma_lite_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .MM2S_START(mm2s_start), .S2MM_START(s2mm_start),
        .MM2S_ADDR(mm2s_addr), .S2MM_ADDR(s2mm_addr),
        .MM2S_LEN(mm2s_len), .S2MM_LEN(s2mm_len),
        .MM2S_DONE(mm2s_done), .S2MM_DONE(s2mm_done),
        .MM2S_IRQ(mm2s_irq), .S2MM_IRQ(s2mm_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each START pulse must match the oldest queued expectation; a stray pulse fails.
    always @(negedge clk) begin
        if (mm2s_start) begin
            check("mm2s_start_expected", 32'(mm2s_q.size() > 0), 32'd1);
            if (mm2s_q.size() > 0) begin
                mm2s_e = mm2s_q.pop_front();
                check("mm2s_start_addr", mm2s_addr, mm2s_e[57:26]);
                check("mm2s_start_len", 32'(mm2s_len), 32'(mm2s_e[25:0]));
            end
        end
        if (s2mm_start) begin
            check("s2mm_start_expected", 32'(s2mm_q.size() > 0), 32'd1);
            if (s2mm_q.size() > 0) begin
                s2mm_e = s2mm_q.pop_front();
                check("s2mm_start_addr", s2mm_addr, s2mm_e[57:26]);
                check("s2mm_start_len", 32'(s2mm_len), 32'(s2mm_e[25:0]));
            end
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input string tag);
        logic aw_done, w_done, got, awh, wh;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            awh = awvalid & awready;
            wh  = wvalid & wready;
            tick();
            if (awh) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (wh) begin w_done = 1'b1; wvalid = 1'b0; end
            if (aw_done && w_done) break;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, "_addr_data_accept"}, 32'(aw_done & w_done), 32'd1);
        for (int i = 0; i < 50; i++) begin
            if (bvalid) begin
                check({tag, "_bresp"}, 32'(bresp), 32'd0);
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
        check({tag, "_b_seen"}, 32'(got), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                            input string tag);
        logic [33:0] e;
        logic        acc, got;
        rd_q.push_back({exp_r, exp_d});
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        acc = 1'b0; got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (arready) begin tick(); acc = 1'b1; break; end
            tick();
        end
        arvalid = 1'b0;
        check({tag, "_ar_accept"}, 32'(acc), 32'd1);
        for (int i = 0; i < 50; i++) begin
            if (rvalid) begin
                e = rd_q.pop_front();
                check({tag, "_rdata"}, rdata, e[31:0]);
                check({tag, "_rresp"}, 32'(rresp), 32'(e[33:32]));
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
        check({tag, "_r_seen"}, 32'(got), 32'd1);
        if (!got && rd_q.size() > 0) e = rd_q.pop_front();
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = 32'h0; awprot = 3'd0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
        bready = 1'b0; araddr = 32'h0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        mm2s_done = 1'b0; s2mm_done = 1'b0;
        repeat (3) tick();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid_rvalid", 32'({bvalid, rvalid}), 32'd0);
        check("rst_start_irq", 32'({mm2s_start, s2mm_start, mm2s_irq, s2mm_irq}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Reset values of every mapped register.
        axi_read(32'h00, 32'h0, 2'b00, "rst_mm2s_cr");
        axi_read(32'h04, 32'h3, 2'b00, "rst_mm2s_sr");
        axi_read(32'h18, 32'h0, 2'b00, "rst_mm2s_sa");
        axi_read(32'h28, 32'h0, 2'b00, "rst_mm2s_len");
        axi_read(32'h30, 32'h0, 2'b00, "rst_s2mm_cr");
        axi_read(32'h34, 32'h3, 2'b00, "rst_s2mm_sr");
        axi_read(32'h48, 32'h0, 2'b00, "rst_s2mm_da");
        axi_read(32'h58, 32'h0, 2'b00, "rst_s2mm_len");

        // S2MM configure and start.
        axi_write(32'h30, 32'h0000_1001, 4'hF, "s2mm_cr");
        axi_write(32'h48, 32'h1000_0000, 4'hF, "s2mm_da");
        s2mm_q.push_back({32'h1000_0000, 26'h400});
        axi_write(32'h58, 32'h0000_0400, 4'hF, "s2mm_len");
        check("s2mm_start_consumed", 32'(s2mm_q.size()), 32'd0);
        check("s2mm_addr_out", s2mm_addr, 32'h1000_0000);
        check("s2mm_len_out", 32'(s2mm_len), 32'h400);
        axi_read(32'h34, 32'h0, 2'b00, "s2mm_sr_busy");
        axi_write(32'h48, 32'hDEAD_0000, 4'hF, "s2mm_da_busy");
        axi_write(32'h58, 32'h0000_0007, 4'hF, "s2mm_len_busy");
        axi_read(32'h48, 32'h1000_0000, 2'b00, "s2mm_da_kept");
        axi_read(32'h58, 32'h0000_0400, 2'b00, "s2mm_len_kept");

        // S2MM completion, interrupt and W1C.
        s2mm_done = 1'b1;
        tick();
        s2mm_done = 1'b0;
        tick();
        check("s2mm_irq_set", 32'(s2mm_irq), 32'd1);
        axi_read(32'h34, 32'h0000_1002, 2'b00, "s2mm_sr_done");
        axi_write(32'h34, 32'h0000_1000, 4'hF, "s2mm_w1c");
        check("s2mm_irq_clr", 32'(s2mm_irq), 32'd0);
        axi_read(32'h34, 32'h0000_0002, 2'b00, "s2mm_sr_clr");

        // W ahead of AW, with the B channel back-pressured.
        bready = 1'b0;
        wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1'b1;
        check("hold_wready_empty", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0;
        check("hold_wready_full", 32'(wready), 32'd0);
        repeat (2) begin
            tick();
            check("hold_w_waits_aw", 32'({wready, awready}), 32'b01);
        end
        awaddr = 32'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("hold_awready_full", 32'(awready), 32'd0);
        check("hold_no_b_yet", 32'(bvalid), 32'd0);
        tick();
        check("hold_b_rises", 32'(bvalid), 32'd1);
        check("hold_ready_freed", 32'({awready, wready}), 32'b11);
        check("hold_first_update", mm2s_addr, 32'hA5A5_0001);
        awaddr = 32'h18; awvalid = 1'b1; wdata = 32'h0000_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold_bvalid_kept", 32'(bvalid), 32'd1);
            check("hold_no_second_update", mm2s_addr, 32'hA5A5_0001);
            tick();
        end
        check("hold_bvalid_kept_last", 32'({bvalid, awready}), 32'b10);
        bready = 1'b1;
        tick();
        check("hold_second_b", 32'(bvalid), 32'd1);
        check("hold_second_update", mm2s_addr, 32'h0000_BEEF);
        tick();
        check("hold_b_drained", 32'(bvalid), 32'd0);

        // MM2S start, then DONE coinciding with a W1C commit.
        axi_write(32'h00, 32'h0000_1001, 4'hF, "mm2s_cr");
        mm2s_q.push_back({32'h0000_BEEF, 26'h10});
        axi_write(32'h28, 32'h0000_0010, 4'hF, "mm2s_len");
        check("mm2s_start_consumed", 32'(mm2s_q.size()), 32'd0);
        awaddr = 32'h04; awvalid = 1'b1; wdata = 32'h0000_1000; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("race_accepted", 32'({awready, wready}), 32'b00);
        mm2s_done = 1'b1;
        tick();
        mm2s_done = 1'b0;
        check("race_b", 32'(bvalid), 32'd1);
        tick();
        axi_read(32'h04, 32'h0000_1002, 2'b00, "race_set_wins");
        check("race_irq", 32'(mm2s_irq), 32'd1);
        axi_write(32'h04, 32'h0000_1000, 4'hF, "mm2s_w1c");
        axi_write(32'h28, 32'h0000_0000, 4'hF, "mm2s_len_zero");
        repeat (2) tick();
        axi_read(32'h28, 32'h0, 2'b00, "mm2s_len_zero_rd");
        axi_read(32'h04, 32'h0000_0002, 2'b00, "mm2s_sr_idle");

        // Byte-lane strobe on SA.
        axi_write(32'h18, 32'h1122_3344, 4'b0001, "mm2s_sa_strb");
        axi_read(32'h18, 32'h0000_BE44, 2'b00, "mm2s_sa_strb_rd");

        // Unmapped offset.
`ifdef DMA_LITE_SLVERR_EN
        axi_read(32'h10, 32'h0, 2'b10, "unmapped_rd");
`else
        axi_read(32'h10, 32'h0, 2'b00, "unmapped_rd");
`endif

        repeat (3) tick();
        check("mm2s_start_q_empty", 32'(mm2s_q.size()), 32'd0);
        check("s2mm_start_q_empty", 32'(s2mm_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
